// File: rtl/transposer_job_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | transposer_sched_pkg : job descriptor layout and scheduler state codes   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package transposer_sched_pkg;

    localparam int AW   = 16;
    localparam int ADIM = 6;

    typedef struct packed {
        logic [1:0]               mode;
        logic                     repack_en;
        logic [AW-1:0]            rreq_num;
        logic [AW-1:0]            raddr_base;
        logic [ADIM-1:0][AW-1:0]  raddr_size;
        logic [ADIM-1:0][AW-1:0]  raddr_stride;
        logic [AW-1:0]            wreq_num;
        logic [AW-1:0]            waddr_base;
        logic [ADIM-1:0][AW-1:0]  waddr_size;
        logic [ADIM-1:0][AW-1:0]  waddr_stride;
        logic [AW-1:0]            packed_dim_size;
        logic [AW-1:0]            unpacked_dim_size;
    } job_desc_t;

    localparam int DESC_W = $bits(job_desc_t);

    typedef enum logic [2:0] {
        SCHED_IDLE  = 3'd0,
        SCHED_LOAD  = 3'd1,
        SCHED_START = 3'd2,
        SCHED_RUN   = 3'd3,
        SCHED_DONE  = 3'd4
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/transposer_job_sched_job_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | job_fifo : synchronous circular FIFO with registered occupancy count     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int              c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == c_depth);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/transposer_job_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | transposer_job_sched : queues transpose jobs and runs them one at a time |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module transposer_job_sched
    import transposer_sched_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int IDW    = 8,
    parameter int CW     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_vld,
    output logic                    cmd_rdy,
    input  job_desc_t               cmd_desc,
    output job_desc_t               cfg,
    output logic                    init_pulse,
    input  logic                    finish,
    output logic                    busy,
    output logic [$clog2(QDEPTH):0] q_count,
    output logic                    done_vld,
    output logic [IDW-1:0]          done_id,
    output logic [CW-1:0]           done_cycles
);

    localparam int              c_qaw    = $clog2(QDEPTH);
    localparam int              c_ew     = IDW + DESC_W;
    localparam logic [c_qaw:0]  c_qdepth = (c_qaw + 1)'(QDEPTH);

    localparam logic [2:0] c_st_idle  = SCHED_IDLE;
    localparam logic [2:0] c_st_load  = SCHED_LOAD;
    localparam logic [2:0] c_st_start = SCHED_START;
    localparam logic [2:0] c_st_run   = SCHED_RUN;
    localparam logic [2:0] c_st_done  = SCHED_DONE;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic            r_cmd_rdy;
    logic            r_busy;
    logic            r_init_pulse;
    logic            r_done_vld;
    logic [IDW-1:0]  r_next_id;
    logic [IDW-1:0]  r_cur_id;
    logic [IDW-1:0]  r_done_id;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_inc;
    logic [CW-1:0]   r_done_cycles;
    job_desc_t       r_cfg;

    logic            w_push;
    logic            w_pop;
    logic [c_ew-1:0] w_head;
    logic [IDW-1:0]  w_head_id;
    job_desc_t       w_head_desc;
    logic [c_qaw:0]  w_q_count;
    logic [c_qaw:0]  w_cnt_nxt;
    logic            w_q_full;
    logic            w_q_empty;

    assign w_push      = cmd_vld & r_cmd_rdy & ~w_q_full;
    assign w_head_id   = w_head[c_ew-1 -: IDW];
    assign w_head_desc = w_head[DESC_W-1:0];
    assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    job_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (c_ew)
    ) u_job_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_din   ({r_next_id, cmd_desc}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_q_count),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (!w_q_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_st_load;
                end
            end
            c_st_load:  w_state_nxt = c_st_start;
            c_st_start: w_state_nxt = c_st_run;
            c_st_run: begin
                if (finish) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                if (!w_q_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_st_load;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Next occupancy lets cmd_rdy and busy be registered yet cycle-accurate.
    always_comb begin
        w_cnt_nxt = w_q_count;
        if (w_push && !w_pop) begin
            w_cnt_nxt = w_q_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_cnt_nxt = w_q_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_cmd_rdy     <= 1'b0;
            r_busy        <= 1'b0;
            r_init_pulse  <= 1'b0;
            r_done_vld    <= 1'b0;
            r_next_id     <= '0;
            r_cur_id      <= '0;
            r_done_id     <= '0;
            r_cnt         <= '0;
            r_done_cycles <= '0;
            r_cfg         <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cmd_rdy    <= (w_cnt_nxt != c_qdepth);
            r_busy       <= (w_state_nxt != c_st_idle) | (w_cnt_nxt != '0);
            r_init_pulse <= (w_state_nxt == c_st_start);
            r_done_vld   <= (w_state_nxt == c_st_done);
            if (w_push) begin
                r_next_id <= r_next_id + 1'b1;
            end
            if (w_pop) begin
                r_cfg    <= w_head_desc;
                r_cur_id <= w_head_id;
            end
            // The START cycle itself counts as cycle 1 of the job.
            if (r_state == c_st_start) begin
                r_cnt <= {{(CW-1){1'b0}}, 1'b1};
            end else if (r_state == c_st_run) begin
                r_cnt <= w_cnt_inc;
            end
            if (r_state == c_st_run && finish) begin
                r_done_cycles <= w_cnt_inc;
                r_done_id     <= r_cur_id;
            end
        end
    end

    assign cmd_rdy     = r_cmd_rdy;
    assign busy        = r_busy;
    assign q_count     = w_q_count;
    assign cfg         = r_cfg;
    assign init_pulse  = r_init_pulse;
    assign done_vld    = r_done_vld;
    assign done_id     = r_done_id;
    assign done_cycles = r_done_cycles;

endmodule
`default_nettype wire

// File: tb/tb_transposer_job_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_transposer_job_sched : bench for transposer_job_sched                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_transposer_job_sched;
    import transposer_sched_pkg::*;

    localparam int QD = 4;

    logic      clk = 1'b0;
    logic      reset;
    logic      cmd_vld;
    logic      finish;
    job_desc_t cmd_desc;

    logic       s_cmd_rdy, s_init, s_busy, s_dv;
    job_desc_t  s_cfg;
    logic [2:0] s_qc;
    logic [1:0] s_did;
    logic [3:0] s_dc;

    logic        d_cmd_rdy, d_init, d_busy, d_dv;
    job_desc_t   d_cfg;
    logic [2:0]  d_qc;
    logic [7:0]  d_did;
    logic [31:0] d_dc;

    transposer_job_sched #(.QDEPTH(QD), .IDW(2), .CW(4)) dut_s (
        .clk(clk), .reset(reset), .cmd_vld(cmd_vld), .cmd_rdy(s_cmd_rdy),
        .cmd_desc(cmd_desc), .cfg(s_cfg), .init_pulse(s_init), .finish(finish),
        .busy(s_busy), .q_count(s_qc), .done_vld(s_dv), .done_id(s_did),
        .done_cycles(s_dc)
    );

    transposer_job_sched #(.QDEPTH(QD), .IDW(8), .CW(32)) dut_d (
        .clk(clk), .reset(reset), .cmd_vld(cmd_vld), .cmd_rdy(d_cmd_rdy),
        .cmd_desc(cmd_desc), .cfg(d_cfg), .init_pulse(d_init), .finish(finish),
        .busy(d_busy), .q_count(d_qc), .done_vld(d_dv), .done_id(d_did),
        .done_cycles(d_dc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic job_desc_t mk_desc(input int k);
        job_desc_t d = '0;
        d.mode                 = 2'((k + 2) % 4);
        d.repack_en            = k[0];
        d.rreq_num             = 16'(8 + k);
        d.raddr_base           = 16'(k * 256 + 1);
        d.raddr_size[0]        = 16'(k + 3);
        d.waddr_stride[ADIM-1] = 16'(k * 7);
        d.wreq_num             = 16'(k + 1);
        d.waddr_base           = 16'(16'hA000 + k);
        d.unpacked_dim_size    = 16'(k + 5);
        return d;
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Job-level reference: queue of pending jobs plus the timing of the job in flight.
    typedef struct { job_desc_t d; int id; } ent_t;
    ent_t      mq[$];
    int        m_next_id = 0, m_init = -1, m_done_at = -1, m_cur_id = 0;
    int        m_done_id = 0, m_pend_id = 0;
    longint    m_done_cyc = 0, m_pend_cyc = 0;
    bit        m_live = 0, m_rdy0 = 1, chk_en = 0;
    job_desc_t m_cfg = '0;

    always @(negedge clk) begin : p_cmp
        bit   exp_rdy, exp_busy, exp_init, exp_dv, accept, free;
        ent_t e;
        if (chk_en && cyc == m_done_at) begin
            m_done_id  = m_pend_id;
            m_done_cyc = m_pend_cyc;
        end
        exp_rdy  = !m_rdy0 && (mq.size() != QD);
        exp_busy = m_live || (mq.size() != 0);
        exp_init = m_live && (cyc == m_init);
        exp_dv   = (cyc == m_done_at);
        if (chk_en) begin
            chk("s_cmd_rdy", s_cmd_rdy, exp_rdy);
            chk("d_cmd_rdy", d_cmd_rdy, exp_rdy);
            chk("s_q_count", s_qc, mq.size());
            chk("d_q_count", d_qc, mq.size());
            chk("s_busy", s_busy, exp_busy);
            chk("d_busy", d_busy, exp_busy);
            chk("s_cfg", s_cfg, m_cfg);
            chk("d_cfg", d_cfg, m_cfg);
            chk("s_init_pulse", s_init, exp_init);
            chk("d_init_pulse", d_init, exp_init);
            chk("s_done_vld", s_dv, exp_dv);
            chk("d_done_vld", d_dv, exp_dv);
            chk("s_done_id", s_did, m_done_id % 4);
            chk("d_done_id", d_did, m_done_id % 256);
            chk("s_done_cycles", s_dc, sat(m_done_cyc, 4));
            chk("d_done_cycles", d_dc, sat(m_done_cyc, 32));
        end
        if (reset) begin
            mq.delete();
            m_next_id = 0; m_live = 0; m_init = -1; m_done_at = -1;
            m_done_id = 0; m_done_cyc = 0; m_cfg = '0; m_rdy0 = 1;
            chk_en = 1;
        end else if (chk_en) begin
            accept = cmd_vld && exp_rdy;
            if (m_live && m_done_at < 0 && finish && cyc > m_init) begin
                m_done_at  = cyc + 1;
                m_pend_id  = m_cur_id;
                m_pend_cyc = cyc - m_init + 1;
            end
            free = !m_live || (cyc == m_done_at);
            if (free && mq.size() > 0) begin
                e = mq.pop_front();
                m_cfg = e.d; m_cur_id = e.id;
                m_init = cyc + 2; m_done_at = -1; m_live = 1;
            end else if (m_live && cyc == m_done_at) begin
                m_live = 0;
            end
            if (accept) begin
                e.d = cmd_desc; e.id = m_next_id;
                mq.push_back(e);
                m_next_id++;
            end
            m_rdy0 = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic push(input job_desc_t d, output int hs);
        int n = 0;
        hs = -1;
        cmd_vld = 1'b1;
        cmd_desc = d;
        while (hs < 0 && n < 60) begin
            if (d_cmd_rdy) hs = cyc;
            step();
            n++;
        end
        cmd_vld = 1'b0;
        if (hs < 0) begin
            checks++; errors++;
            $display("FAIL push_timeout cycle %0d: got no cmd_rdy expected handshake", cyc);
        end
    endtask

    task automatic wait_init(output int ic);
        int n = 0;
        ic = -1;
        while (ic < 0 && n < 60) begin
            if (d_init) ic = cyc;
            else begin step(); n++; end
        end
        if (ic < 0) begin
            checks++; errors++;
            $display("FAIL init_timeout cycle %0d: got no init_pulse expected one", cyc);
        end
    endtask

    // Leaves the bench in the cycle where done_vld is due.
    task automatic run_job(input int after, output int ic);
        wait_init(ic);
        if (ic >= 0) begin
            while (cyc < ic + after) step();
            finish = 1'b1;
            step();
            finish = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d: got no finish expected end of run", cyc);
        $fatal(1);
    end

    int t0, h, ic, hh, icw;
    int h2[6];
    int ic3[3];
    int wrap_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset = 1'b1; cmd_vld = 1'b0; finish = 1'b0; cmd_desc = '0;
        do_reset(3);
        chk("rst_cmd_rdy_low", d_cmd_rdy, 0);
        step();

        // single job
        push(mk_desc(0), t0);
        chk("t1_q_count", d_qc, 1);
        chk("t1_busy", d_busy, 1);
        step();
        chk("t1_cfg", d_cfg, mk_desc(0));
        chk("t1_cfg_mode", d_cfg.mode, 2);
        chk("t1_init_early", d_init, 0);
        step();
        chk("t1_init", d_init, 1);
        step();
        chk("t1_init_once", d_init, 0);
        while (cyc < t0 + 13) step();
        finish = 1'b1; step(); finish = 1'b0;
        chk("t1_done_vld", d_dv, 1);
        chk("t1_done_id", d_did, 0);
        chk("t1_done_cycles", d_dc, 11);
        chk("t1_done_cycles_s", s_dc, 11);
        step();
        chk("t1_busy_low", d_busy, 0);
        chk("t1_done_vld_low", d_dv, 0);
        chk("t1_done_hold", d_dc, 11);

        // queue full
        do_reset(2);
        for (int i = 0; i < 5; i++) push(mk_desc(10 + i), h2[i]);
        chk("t2_back_to_back", h2[4] - h2[0], 4);
        chk("t2_q_count_full", d_qc, 4);
        chk("t2_cmd_rdy_full", d_cmd_rdy, 0);
        fork
            push(mk_desc(15), h2[5]);
            begin
                while (cyc < h2[0] + 8) step();
                finish = 1'b1; step(); finish = 1'b0;
                chk("t2_first_done_cycles", d_dc, 6);
            end
        join
        chk("t2_stall_release", h2[5] - h2[0], 10);
        for (int i = 0; i < 5; i++) begin
            run_job(2, ic);
            chk("t2_drain_id", d_did, i + 1);
        end
        step(); step();
        chk("t2_idle", d_busy, 0);

        // back-to-back
        do_reset(1);
        for (int i = 0; i < 3; i++) push(mk_desc(20 + i), h);
        for (int i = 0; i < 3; i++) begin
            run_job(5, ic3[i]);
            chk("t3_done_id", d_did, i);
            chk("t3_done_cycles", d_dc, 6);
        end
        chk("t3_spacing_a", ic3[1] - ic3[0], 8);
        chk("t3_spacing_b", ic3[2] - ic3[1], 8);

        // spurious finish
        do_reset(1);
        step();
        finish = 1'b1; step(); finish = 1'b0;
        chk("t4_idle_finish_busy", d_busy, 0);
        chk("t4_idle_finish_dv", d_dv, 0);
        push(mk_desc(30), h);
        wait_init(ic);
        finish = 1'b1; step(); finish = 1'b0;
        chk("t4_early_finish_dv", d_dv, 0);
        while (cyc < ic + 4) step();
        finish = 1'b1; step(); finish = 1'b0;
        chk("t4_done_vld", d_dv, 1);
        chk("t4_done_cycles", d_dc, 5);

        // reset mid-RUN
        do_reset(1);
        for (int i = 0; i < 3; i++) push(mk_desc(40 + i), h);
        wait_init(ic);
        step(); step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("t5_q_count", d_qc, 0);
        chk("t5_busy", d_busy, 0);
        chk("t5_cfg", d_cfg, 0);
        chk("t5_cmd_rdy", d_cmd_rdy, 0);
        finish = 1'b1; step(); finish = 1'b0;
        step();
        chk("t5_late_finish", d_dv, 0);
        push(mk_desc(45), h);
        run_job(3, ic);
        chk("t5_id_restart", d_did, 0);
        chk("t5_done_cycles", d_dc, 4);

        // id wrap and counter saturation
        do_reset(1);
        fork
            for (int i = 0; i < 5; i++) push(mk_desc(50 + i), hh);
            for (int j = 0; j < 5; j++) begin
                run_job(2, icw);
                chk("t6_wrap_id_s", s_did, wrap_exp[j]);
                chk("t6_id_d", d_did, j);
            end
        join
        push(mk_desc(60), h);
        run_job(20, ic);
        chk("t6_sat_s", s_dc, 15);
        chk("t6_nosat_d", d_dc, 21);
        chk("t6_id_s", s_did, 1);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
